pc_fetch_ctrl: RTL

- Instruction-fetch sequencer for the single-issue MIPS core.
- Owns the fetch PC register and drives the instruction-memory request/acknowledge handshake.
- Buffers one fetched instruction toward decode, and applies redirects (branch/jump/jr) computed from the same NPC op encoding the datapath uses.
- Kills in-flight fetches on redirect and flags fatal fetch faults.

---
 rtl/pc_fetch_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs the imem req/ack handshake,
// buffers one instruction toward decode and applies branch/jump/jr redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_3000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [2:0]  npc_op,
  input  logic [25:0] imm,
  input  logic [31:0] rs,
  input  logic [31:0] br_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic [31:0] fetch_pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_KILL, S_HALT} state_e;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic        pending_q, pending_d;
  logic        fetch_err_q, fetch_err_d;
  logic [7:0]  tmo_q, tmo_d;

  logic [31:0] br_off;
  logic [31:0] target;
  logic        redir;

  always_comb begin
    br_off = {{14{imm[15]}}, imm[15:0], 2'b00};
    case (npc_op)
      3'd1:    target = br_pc + 32'd4 + br_off;
      3'd2:    target = {br_pc[31:28], imm, 2'b00};
      3'd3:    target = rs;
      default: target = br_pc + 32'd4;
    endcase
    redir = redirect_valid && !npc_op[2] && (state_q != S_HALT);
  end

  // A request, once raised, is held until acked (pending_q), independent of decode stall.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc_q;
    case (state_q)
      S_FETCH: imem_req = pending_q | ~if_valid_q | if_ready;
      S_KILL: begin
        imem_req  = 1'b1;
        imem_addr = kill_addr_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    kill_addr_d = kill_addr_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    if_valid_d  = if_valid_q;
    pending_d   = pending_q;
    fetch_err_d = fetch_err_q;
    tmo_d       = (imem_req && !imem_ack) ? tmo_q + 8'd1 : 8'd0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        pending_d = imem_req & ~imem_ack;
        if (imem_req && imem_ack) begin
          if_instr_d = imem_rdata;
          if_pc_d    = fetch_pc_q;
          if_valid_d = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end else if (if_valid_q && if_ready) begin
          if_valid_d = 1'b0;
        end
      end
      S_KILL: begin
        if (imem_ack) begin
          state_d   = S_FETCH;
          pending_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Redirect overrides any load above; an unacked request must be drained in KILL.
    if (redir) begin
      if_valid_d = 1'b0;
      fetch_pc_d = target;
      if (state_q == S_FETCH && imem_req && !imem_ack) begin
        state_d     = S_KILL;
        kill_addr_d = imem_addr;
        pending_d   = 1'b0;
      end
    end

    if ((redir && target[1:0] != 2'b00) || (tmo_d >= TMO_LIMIT)) begin
      fetch_err_d = 1'b1;
      if_valid_d  = 1'b0;
      pending_d   = 1'b0;
      state_d     = S_HALT;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      kill_addr_q <= RESET_PC;
      if_instr_q  <= 32'd0;
      if_pc_q     <= 32'd0;
      if_valid_q  <= 1'b0;
      pending_q   <= 1'b0;
      fetch_err_q <= 1'b0;
      tmo_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      kill_addr_q <= kill_addr_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      if_valid_q  <= if_valid_d;
      pending_q   <= pending_d;
      fetch_err_q <= fetch_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign fetch_pc  = fetch_pc_q;
  assign fetch_err = fetch_err_q;

endmodule
